inv_mix_columns_iter: RTL

//  Iterative AES InvMixColumns for the decrypt path; inverse of the forward mix_columns stage.

---
 rtl/inv_mix_columns_iter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns over a 4x4 byte state.
// The work register is transformed in place, COLS_PER_CYCLE columns per clock.
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0][3:0][7:0]  input_matrix,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0][3:0][7:0]  output_matrix,
  output logic                  busy
);

  localparam int         CPC  = COLS_PER_CYCLE;
  localparam logic [1:0] STEP = 2'(CPC);
  localparam logic [1:0] LAST = 2'(4 - CPC);

  if ((CPC != 1) && (CPC != 2) && (CPC != 4)) begin : g_bad_cpc
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q;
  logic [1:0]             col_cnt_q;
  logic [3:0][3:0][7:0]   work_q;
  logic [3:0][3:0][7:0]   work_upd;
  logic                   rdy_q;
  logic                   accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 09/0b/0d/0e built from the x2/x4/x8 chain of each byte
  function automatic logic [3:0][7:0] inv_col(
    input logic [3:0][7:0] a
  );
    logic [3:0][7:0] x2, x4, x8;
    logic [3:0][7:0] m9, mb, md, me;
    logic [3:0][7:0] o;
    for (int r = 0; r < 4; r++) begin
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    o[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    o[1] = me[1] ^ mb[2] ^ md[3] ^ m9[0];
    o[2] = me[2] ^ mb[3] ^ md[0] ^ m9[1];
    o[3] = me[3] ^ mb[0] ^ md[1] ^ m9[2];
    return o;
  endfunction

  always_comb begin
    work_upd = work_q;
    for (int g = 0; g < CPC; g++) begin
      work_upd[col_cnt_q + 2'(g)] =
        inv_col(work_q[col_cnt_q + 2'(g)]);
    end
  end

  // rdy_q keeps in_ready low until the first clock after reset release
  assign in_ready = rdy_q &
                    ((state_q == IDLE) |
                     ((state_q == DONE) & out_ready));
  assign accept        = in_valid & in_ready;
  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign output_matrix = work_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_cnt_q <= 2'd0;
      work_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (clear) begin
        state_q   <= IDLE;
        col_cnt_q <= 2'd0;
      end else begin
        unique case (1'b1)
          (state_q == IDLE): begin
            if (accept) begin
              work_q    <= input_matrix;
              col_cnt_q <= 2'd0;
              state_q   <= BUSY;
            end
          end
          (state_q == BUSY): begin
            work_q    <= work_upd;
            col_cnt_q <= col_cnt_q + STEP;
            if (col_cnt_q == LAST) begin
              state_q <= DONE;
            end
          end
          (state_q == DONE): begin
            if (out_ready) begin
              if (accept) begin
                work_q    <= input_matrix;
                col_cnt_q <= 2'd0;
                state_q   <= BUSY;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
